// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the slave-mux state type.
// Holds HTRANS/HRESP encodings and mux_state_t; no ports.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ROUTE = 2'd0,
      ERR1  = 2'd1,
      ERR2  = 2'd2
   } mux_state_t;

endpackage

// File: rtl/ahb_onehot_enc.sv
// ahb_onehot_enc: select vector to index, plus valid (exactly one bit set)
// and multi (two or more set). Ports: sel in N; idx out IW; vld, multi out 1.
module ahb_onehot_enc #(
   parameter int N  = 7,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  sel,
   output logic [IW-1:0] idx,
   output logic          vld,
   output logic          multi
);

   localparam logic [N-1:0] ONE = N'(1);

   // Clearing the lowest set bit leaves something only if 2+ bits were set.
   assign multi = |(sel & (sel - ONE));
   assign vld   = (|sel) & ~multi;

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (sel[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/ahblite_slave_mux_n.sv
// ahblite_slave_mux_n: AHB-Lite N-port slave response mux with decode-error
// responder and optional wait-state watchdog (macro SLVMUX_WATCHDOG_EN).
// Ports: HCLK, HRESET (sync, active high), HREADY, HTRANS[1:0], HSEL[NPORT],
//   S_HREADYOUT[NPORT], S_HRESP[NPORT], S_HRDATA[NPORT*DW] in;
//   HREADYOUT, HRESP, HRDATA[DW], DECERR, TOERR out.
module ahblite_slave_mux_n
   import ahb_pkg::*;
#(
   parameter int NPORT  = 7,
   parameter int DW     = 32,
   parameter int TO_CYC = 255
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                HREADY,
   input  logic [1:0]          HTRANS,
   input  logic [NPORT-1:0]    HSEL,
   input  logic [NPORT-1:0]    S_HREADYOUT,
   input  logic [NPORT-1:0]    S_HRESP,
   input  logic [NPORT*DW-1:0] S_HRDATA,
   output logic                HREADYOUT,
   output logic                HRESP,
   output logic [DW-1:0]       HRDATA,
   output logic                DECERR,
   output logic                TOERR
);

   localparam int IW = $clog2(NPORT);

   mux_state_t    state_q, state_d;
   logic [IW-1:0] own_idx_q, own_idx_d;
   logic          own_vld_q, own_vld_d;
   logic          dec_q, dec_d;

   logic [IW-1:0] sel_idx;
   logic          sel_vld, sel_multi;
   logic          trans_act, dec_err, to_hit;
   logic          slv_rdy, slv_resp;
   logic [DW-1:0] slv_data;

   ahb_onehot_enc #(
      .N  (NPORT),
      .IW (IW)
   ) u_enc (
      .sel   (HSEL),
      .idx   (sel_idx),
      .vld   (sel_vld),
      .multi (sel_multi)
   );

   assign trans_act = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
   assign dec_err   = HREADY && trans_act && (~|HSEL || sel_multi);

   always_comb begin
      slv_rdy  = 1'b1;
      slv_resp = HRESP_OKAY;
      slv_data = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (own_idx_q == IW'(i)) begin
            slv_rdy  = S_HREADYOUT[i];
            slv_resp = S_HRESP[i];
            slv_data = S_HRDATA[i*DW +: DW];
         end
      end
   end

`ifdef SLVMUX_WATCHDOG_EN
   logic [15:0] wd_q;
   logic        wd_wait;
   logic        to_q;

   assign wd_wait = (state_q == ROUTE) && own_vld_q && !slv_rdy;
   assign to_hit  = wd_wait && (wd_q == 16'(TO_CYC - 1));

   // An HREADY-high edge starts a new data phase, so the count restarts.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         to_q <= to_hit;
         wd_q <= (wd_wait && !HREADY && !to_hit) ? wd_q + 16'd1 : '0;
      end
   end

   assign TOERR = to_q;
`else
   assign to_hit = 1'b0;
   assign TOERR  = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      own_idx_d = own_idx_q;
      own_vld_d = own_vld_q;
      dec_d     = 1'b0;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = '0;
      unique case (state_q)
         ROUTE: begin
            if (own_vld_q) begin
               HREADYOUT = slv_rdy;
               HRESP     = slv_resp;
               HRDATA    = slv_data;
            end
            // Timeout drops the late slave; its data phase is never routed.
            if (to_hit) begin
               state_d   = ERR1;
               own_vld_d = 1'b0;
            end else if (HREADY) begin
               own_idx_d = sel_idx;
               own_vld_d = sel_vld;
               if (dec_err) begin
                  state_d = ERR1;
                  dec_d   = 1'b1;
               end
            end
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            own_vld_d = 1'b0;
            state_d   = ERR2;
         end
         ERR2: begin
            HRESP   = HRESP_ERROR;
            state_d = ROUTE;
            if (HREADY) begin
               own_idx_d = sel_idx;
               own_vld_d = sel_vld;
               if (dec_err) begin
                  state_d = ERR1;
                  dec_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d   = ROUTE;
            own_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= ROUTE;
         own_idx_q <= '0;
         own_vld_q <= 1'b0;
         dec_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         own_idx_q <= own_idx_d;
         own_vld_q <= own_vld_d;
         dec_q     <= dec_d;
      end
   end

   assign DECERR = dec_q;

endmodule
